// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, default sizes and parity helper for the PS/2 receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int DEF_FIFO_DEPTH  = 16;
    localparam int DEF_FILT_LEN    = 8;
    localparam int DEF_TIMEOUT_CYC = 100000;

    // True when data byte plus parity bit carry an odd number of ones
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - synchronous show-ahead FIFO; a push while full is dropped unless a pop frees the slot
module ps2_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      cnt <= cnt + (AW + 1)'(1);
            else if (!do_push && do_pop) cnt <= cnt - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host receiver: pin conditioning, frame decode, byte FIFO, sticky flags
// Defining PS2RX_TIMEOUT_EN adds a mid-frame idle timeout that aborts the frame and sets ferr.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int FILT_LEN    = DEF_FILT_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          PS2_CLK,
    input  logic                          PS2_DAT,
    input  logic                          rd,
    input  logic                          clr_err,
    output logic [7:0]                    rdata,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          perr,
    output logic                          ferr,
    output logic                          ovf,
    output logic                          busy
);
    localparam int FW = $clog2(FILT_LEN) + 1;
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);

    logic [1:0]  clk_sync;
    logic [1:0]  dat_sync;
    logic        clk_lvl;
    logic [FW-1:0] filt_cnt;
    logic        fall;
    logic        dat;

    ps2_state_t  state, state_n;
    logic [7:0]  sr, sr_n;
    logic [2:0]  bitcnt, bitcnt_n;
    logic        par_ok, par_ok_n;
    logic        push, set_perr, set_ferr;
    logic        timeout;
    logic        fifo_full, fifo_empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
        end
    end

    assign dat = dat_sync[1];

    // Level only follows the pin after FILT_LEN consecutive disagreeing samples
    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_lvl  <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync[1] == clk_lvl) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_MAX) begin
            clk_lvl  <= ~clk_lvl;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign fall = clk_lvl && !clk_sync[1] && (filt_cnt == FILT_MAX);

`ifdef PS2RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge CLK) begin
        if (RST || fall || state == IDLE) to_cnt <= '0;
        else                              to_cnt <= to_cnt + TW'(1);
    end

    assign timeout = (state != IDLE) && (to_cnt == TO_MAX);
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            sr     <= '0;
            bitcnt <= '0;
            par_ok <= 1'b0;
        end else begin
            state  <= state_n;
            sr     <= sr_n;
            bitcnt <= bitcnt_n;
            par_ok <= par_ok_n;
        end
    end

    always_comb begin
        state_n  = state;
        sr_n     = sr;
        bitcnt_n = bitcnt;
        par_ok_n = par_ok;
        push     = 1'b0;
        set_perr = 1'b0;
        set_ferr = 1'b0;
        if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!dat) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                    end
                end
                DATA: begin
                    sr_n     = {dat, sr[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_ok_n = odd_parity_ok({sr, dat});
                    state_n  = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!dat)        set_ferr = 1'b1;
                    else if (par_ok) push     = 1'b1;
                    else             set_perr = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end else if (timeout) begin
            state_n  = IDLE;
            set_ferr = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    ps2_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .wdata (sr),
        .pop   (rd),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign empty = fifo_empty;

    // A set event in the same cycle as clr_err wins
    always_ff @(posedge CLK) begin
        if (RST) begin
            perr <= 1'b0;
            ferr <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (set_perr)     perr <= 1'b1;
            else if (clr_err) perr <= 1'b0;
            if (set_ferr)     ferr <= 1'b1;
            else if (clr_err) ferr <= 1'b0;
            if (push && fifo_full && !(rd && !fifo_empty)) ovf <= 1'b1;
            else if (clr_err)                              ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - directed and random PS/2 frames checked against a queue-based reference model
module tb_ps2_rx;
    localparam int DEPTH  = 16;
    localparam int FILT   = 8;
    localparam int TO_CYC = 300;
    localparam int H      = 25;

    logic       CLK = 1'b0;
    logic       RST, PS2_CLK, PS2_DAT, rd, clr_err;
    logic [7:0] rdata;
    logic       empty, perr, ferr, ovf, busy;
    logic [4:0] count;

    always #10 CLK = ~CLK;

    ps2_rx #(
        .FIFO_DEPTH  (DEPTH),
        .FILT_LEN    (FILT),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .rd      (rd),
        .clr_err (clr_err),
        .rdata   (rdata),
        .empty   (empty),
        .count   (count),
        .perr    (perr),
        .ferr    (ferr),
        .ovf     (ovf),
        .busy    (busy)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] mq[$];
    logic       m_perr, m_ferr, m_ovf;
    logic [10:0] f;
    logic [7:0] b;
    int         k, n;

    task automatic cyc(input int c);
        repeat (c) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic exp_busy);
        chk({tag, ":count"}, 32'(count), 32'(mq.size()));
        chk({tag, ":empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ":rdata"}, 32'(rdata), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        chk({tag, ":perr"},  32'(perr),  32'(m_perr));
        chk({tag, ":ferr"},  32'(ferr),  32'(m_ferr));
        chk({tag, ":ovf"},   32'(ovf),   32'(m_ovf));
        chk({tag, ":busy"},  32'(busy),  32'(exp_busy));
    endtask

    // Frame bits in wire order: start, data LSB first, odd parity, stop
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        logic par;
        par = (($countones(d) % 2) == 0) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    task automatic model_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        if (bad_stop)              m_ferr = 1'b1;
        else if (bad_par)          m_perr = 1'b1;
        else if (mq.size() == DEPTH) m_ovf = 1'b1;
        else                       mq.push_back(d);
    endtask

    task automatic send_bit(input logic v);
        PS2_DAT = v;
        cyc(H);
        PS2_CLK = 1'b0;
        cyc(H);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_range(input logic [10:0] fr, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(fr[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        send_range(mk_frame(d, bad_par, bad_stop), 0, 10);
        cyc(H);
        model_frame(d, bad_par, bad_stop);
    endtask

    task automatic pop_one(input string tag);
        chk({tag, ":head"}, 32'(rdata), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic clr();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    initial begin
        RST = 1'b1; PS2_CLK = 1'b1; PS2_DAT = 1'b1; rd = 1'b0; clr_err = 1'b0;
        m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        mq.delete();
        cyc(5);
        RST = 1'b0;
        cyc(1);
        check_state("reset", 1'b0);

        send_frame(8'h1C, 1'b0, 1'b0);
        check_state("f1C", 1'b0);
        send_frame(8'hF0, 1'b1, 1'b0);
        check_state("perr", 1'b0);
        clr();
        check_state("clr_perr", 1'b0);
        pop_one("pop1C");
        check_state("after_pop", 1'b0);

        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 1'b0);
        check_state("full_ovf", 1'b0);
        while (mq.size() > 0) pop_one("drain");
        check_state("drained", 1'b0);
        pop_one("rd_empty");
        check_state("rd_empty", 1'b0);
        clr();

        PS2_CLK = 1'b0; cyc(1); PS2_CLK = 1'b1; cyc(20);
        check_state("glitch1", 1'b0);
        PS2_DAT = 1'b0; cyc(2);
        PS2_CLK = 1'b0; cyc(7); PS2_CLK = 1'b1; cyc(20);
        check_state("glitch7", 1'b0);
        f = mk_frame(8'h33, 1'b0, 1'b0);
        PS2_CLK = 1'b0; cyc(8); PS2_CLK = 1'b1; cyc(20);
        check_state("glitch8", 1'b1);
        send_range(f, 1, 10);
        cyc(H);
        model_frame(8'h33, 1'b0, 1'b0);
        check_state("glitch8_frame", 1'b0);
        pop_one("pop33");

`ifdef PS2RX_TIMEOUT_EN
        f = mk_frame(8'hA5, 1'b0, 1'b0);
        send_range(f, 0, 3);
        check_state("to_mid", 1'b1);
        cyc(TO_CYC + 10);
        m_ferr = 1'b1;
        check_state("to_done", 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0);
        check_state("to_5A", 1'b0);
        pop_one("pop5A");
        clr();
`else
        f = mk_frame(8'hA5, 1'b0, 1'b0);
        send_range(f, 0, 3);
        cyc(2 * TO_CYC);
        check_state("hold_mid", 1'b1);
        send_range(f, 4, 10);
        cyc(H);
        model_frame(8'hA5, 1'b0, 1'b0);
        check_state("hold_done", 1'b0);
        pop_one("popA5");
`endif

        repeat (30) begin
            b = 8'($urandom);
            k = $urandom_range(0, 9);
            send_frame(b, k == 0, k == 1);
            check_state("rnd", 1'b0);
            n = $urandom_range(0, 2);
            repeat (n) pop_one("rnd_rd");
            if ($urandom_range(0, 4) == 0) clr();
            check_state("rnd_post", 1'b0);
        end

        while (mq.size() > 0) pop_one("drain2");
        clr();
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 1'b0);
        check_state("three", 1'b0);
        f = mk_frame(8'h29, 1'b0, 1'b0);
        send_range(f, 0, 4);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        mq.delete();
        m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        check_state("rst_mid", 1'b0);
        cyc(H);
        send_frame(8'h29, 1'b0, 1'b0);
        check_state("after_rst_29", 1'b0);
        pop_one("pop29");
        check_state("final", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
